usb_stdreply: RTL and testbench
===============================

USB_STDREPLY -- requirements
Module: usb_stdreply

Interface
REQ-001 SHALL have ports (name direction width meaning), clock and reset first:
- clk  in  1  single clock.
- rst0_async  in  1  asynchronous reset, active-low.
- bm_request_type, b_request  in  8 each  SETUP fields.
- w_index  in  4  target endpoint/interface number.
- w_length  in  16  host-requested data length.
- trsac_type  in  2  transaction type: 0 SETUP, 1 OUT, 2 IN.
- trsac_ep  in  4  transaction endpoint.
- trsac_req_in  in  2  request status from user: 0 OK, 1 ACTIVE, 2 FAIL.
- trsac_reply_in  in  2  reply from user: 0 ACK, 1 NAK, 2 STALL.
- trsac_req_out  out  2  request status to the transaction engine.
- trsac_reply_out  out  2  reply to the transaction engine.
- dev_configval  in  8  current configuration value.
- ep_halt  in  16  per-endpoint halt flags.
- tx_rd  in  1  one-cycle strobe: the engine consumes the current byte.
- tx_data  out  8  current IN byte.
- tx_last  out  1  tx_data is the final byte of the data stage.
- tx_zlp  out  1  the data stage is zero-length.
REQ-002 SHALL have parameters (name, default, meaning): SELF_POWERED, 0, GetStatus(device) bit0; REMOTE_WAKEUP, 0, GetStatus(device) bit1.

Function
REQ-003 SHALL intercept SETUP on ep0 with these standard requests:
- GetConfiguration: bm=0x80, b=0x08; natural length 1.
- GetStatus(device): bm=0x80, b=0x00; natural length 2.
- GetStatus(interface): bm=0x81, b=0x00; natural length 2.
- GetStatus(endpoint): bm=0x82, b=0x00; natural length 2.
REQ-004 SHALL pass every other transaction to the user unchanged (req_out=req_in, reply_out=reply_in, same cycle) while in BYPASS.
REQ-005 SHALL use states IDLE, SETUP, DATA_IN, STATUS_OUT, BYPASS.
REQ-006 SHALL leave IDLE on trsac_req_in==ACTIVE: to SETUP if the SETUP/ep0 request is intercepted, else to BYPASS.
REQ-007 SHALL, in SETUP, drive req_out=trsac_req_in and reply_out=ACK; latch the request kind and len=min(w_length, natural length); go to DATA_IN on OK, or to IDLE on FAIL.
REQ-008 SHALL define the data bytes:
- GetConfiguration: dev_configval.
- GetStatus(device): {6'b0, REMOTE_WAKEUP, SELF_POWERED}, then 0x00.
- GetStatus(interface): 0x00, 0x00.
- GetStatus(endpoint): {7'b0, ep_halt[w_index]}, then 0x00; w_index is latched in SETUP.
REQ-009 SHALL keep a byte counter cnt (2 bits): tx_data=byte[cnt] combinationally; tx_last=(cnt==len-1); tx_zlp=(len==0); tx_rd increments cnt and saturates at len.
REQ-010 SHALL, in DATA_IN, answer an IN/ep0 transaction with reply_out=ACK; on OK go to STATUS_OUT; on FAIL reset cnt to 0 and stay in DATA_IN (host retry).
REQ-011 SHALL, in STATUS_OUT, ACK an OUT/ep0 transaction and return to IDLE on OK or FAIL.
REQ-012 SHALL, on a SETUP/ep0 with ACTIVE in DATA_IN or STATUS_OUT, abort and re-decode it in the same cycle as IDLE would.
REQ-013 SHALL treat a non-ep0 transaction arriving in DATA_IN or STATUS_OUT as a one-transaction bypass and then resume the saved state.
REQ-014 SHALL return from BYPASS to IDLE when trsac_req_in != ACTIVE.
REQ-015 SHALL drive req_out=req_in outside BYPASS, so transaction status is always visible.

Reset
REQ-016 SHALL, on rst0_async low, asynchronously set: state IDLE, cnt 0, len 0, latched kind/index 0, tx_data 0x00, tx_last 0, tx_zlp 1, trsac_req_out OK, trsac_reply_out ACK.
REQ-017 SHALL abandon any control transfer in progress when reset asserts mid-transfer, with no further output after release until a new SETUP arrives.

Structure
REQ-018 SHALL take the REQ_*, REPLY_*, TYPE_* codes and the request/bm constants from a shared usb package, also used by the request-setting block.
REQ-019 SHALL use a single sub-module usb_stdreply_rom that maps (kind, cnt, dev_configval, ep_halt bit) to tx_data combinationally.

Verification
REQ-020 SHALL cover these directed scenarios:
- GetConfiguration with w_length=64, dev_configval=0x03 -> 1 byte 0x03, tx_last=1, STATUS OUT ACKed, back in IDLE.
- GetStatus(endpoint) with w_index=2, ep_halt=0x0004 -> bytes 0x01, 0x00; with w_length=1 -> byte 0x01 only, tx_last=1.
- GetStatus(device) with w_length=0 -> tx_zlp=1, IN ACKed, STATUS ACKed.
- First IN ends FAIL -> cnt=0, retry IN sends the same bytes again (0x01/0x00 for GetStatus(device), SELF_POWERED=1).
- Vendor SETUP bm=0x40 -> user reply NAK/STALL seen on reply_out same cycle, state BYPASS, then IDLE.
- New SETUP during STATUS_OUT, and rst0_async pulse during DATA_IN -> abort; outputs equal REQ-016 values.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB control definitions: transaction status/reply/type codes,
// standard-request constants, request kinds and the decode/length helpers
// used by usb_stdreply and the request-setting logic.
package usb_pkg;

    localparam int unsigned CODE_W  = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned EP_W    = 4;
    localparam int unsigned WLEN_W  = 16;
    localparam int unsigned BYTE_W  = 8;

    // Request status between user, this block and the transaction engine.
    localparam logic [CODE_W-1:0] REQ_OK     = 2'd0;
    localparam logic [CODE_W-1:0] REQ_ACTIVE = 2'd1;
    localparam logic [CODE_W-1:0] REQ_FAIL   = 2'd2;

    // Handshake reply to the transaction engine.
    localparam logic [CODE_W-1:0] REPLY_ACK   = 2'd0;
    localparam logic [CODE_W-1:0] REPLY_NAK   = 2'd1;
    localparam logic [CODE_W-1:0] REPLY_STALL = 2'd2;

    // Transaction type.
    localparam logic [CODE_W-1:0] TYPE_SETUP = 2'd0;
    localparam logic [CODE_W-1:0] TYPE_OUT   = 2'd1;
    localparam logic [CODE_W-1:0] TYPE_IN    = 2'd2;

    // bmRequestType values for device-to-host standard requests.
    localparam logic [BYTE_W-1:0] BM_STD_DEV_IN = 8'h80;
    localparam logic [BYTE_W-1:0] BM_STD_IF_IN  = 8'h81;
    localparam logic [BYTE_W-1:0] BM_STD_EP_IN  = 8'h82;

    // bRequest codes.
    localparam logic [BYTE_W-1:0] B_GET_STATUS        = 8'h00;
    localparam logic [BYTE_W-1:0] B_GET_CONFIGURATION = 8'h08;

    typedef enum logic [2:0] {
        KIND_NONE    = 3'd0,
        KIND_GET_CFG = 3'd1,
        KIND_STS_DEV = 3'd2,
        KIND_STS_IF  = 3'd3,
        KIND_STS_EP  = 3'd4
    } req_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_DATA_IN    = 3'd2,
        ST_STATUS_OUT = 3'd3,
        ST_BYPASS     = 3'd4
    } stdreply_state_e;

    // SETUP packet fields this block cares about.
    typedef struct packed {
        logic [BYTE_W-1:0] bm_request_type;
        logic [BYTE_W-1:0] b_request;
        logic [EP_W-1:0]   w_index;
        logic [WLEN_W-1:0] w_length;
    } setup_pkt_t;

    // Map a SETUP header onto one of the intercepted standard requests.
    function automatic req_kind_e decode_std_req(input logic [BYTE_W-1:0] bm,
                                                 input logic [BYTE_W-1:0] b);
        req_kind_e k;
        k = KIND_NONE;
        if (b == B_GET_CONFIGURATION) begin
            if (bm == BM_STD_DEV_IN) k = KIND_GET_CFG;
        end else if (b == B_GET_STATUS) begin
            case (bm)
                BM_STD_DEV_IN: k = KIND_STS_DEV;
                BM_STD_IF_IN:  k = KIND_STS_IF;
                BM_STD_EP_IN:  k = KIND_STS_EP;
                default:       k = KIND_NONE;
            endcase
        end
        return k;
    endfunction

    // Full data-stage length of each intercepted request.
    function automatic logic [CNT_W-1:0] natural_len(input req_kind_e k);
        logic [CNT_W-1:0] n;
        case (k)
            KIND_GET_CFG: n = CNT_W'(1);
            KIND_STS_DEV,
            KIND_STS_IF,
            KIND_STS_EP:  n = CNT_W'(2);
            default:      n = '0;
        endcase
        return n;
    endfunction

    // Data-stage length actually sent: the host may ask for fewer bytes.
    function automatic logic [CNT_W-1:0] clip_len(input logic [WLEN_W-1:0] wlen,
                                                  input logic [CNT_W-1:0]  nat);
        logic [CNT_W-1:0] n;
        if (wlen < WLEN_W'(nat)) n = wlen[CNT_W-1:0];
        else                     n = nat;
        return n;
    endfunction

endpackage

// File: rtl/usb_stdreply_rom.sv
// Data-stage byte table for the intercepted standard requests.
// Ports:
//   kind_i      latched request kind
//   cnt_i       index of the byte currently presented
//   configval_i current configuration value (GetConfiguration)
//   halt_i      halt flag of the latched endpoint (GetStatus(endpoint))
//   data_o      byte at index cnt_i (combinational)
module usb_stdreply_rom
    import usb_pkg::*;
#(
    parameter bit SELF_POWERED  = 1'b0,
    parameter bit REMOTE_WAKEUP = 1'b0
) (
    input  req_kind_e          kind_i,
    input  logic [CNT_W-1:0]   cnt_i,
    input  logic [BYTE_W-1:0]  configval_i,
    input  logic               halt_i,
    output logic [BYTE_W-1:0]  data_o
);

    // Only byte 0 carries information; every later byte is 0x00.
    always_comb begin
        data_o = '0;
        if (cnt_i == '0) begin
            case (kind_i)
                KIND_GET_CFG: data_o = configval_i;
                KIND_STS_DEV: data_o = {6'b0, REMOTE_WAKEUP, SELF_POWERED};
                KIND_STS_EP:  data_o = {7'b0, halt_i};
                default:      data_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/usb_stdreply.sv
// Answers the standard GetConfiguration / GetStatus control requests on
// endpoint 0 and passes every other transaction through to the user.
// Ports:
//   clk, rst0_async                 clock, async active-low reset
//   bm_request_type, b_request,
//   w_index, w_length               SETUP fields
//   trsac_type, trsac_ep            current transaction type / endpoint
//   trsac_req_in, trsac_reply_in    status / reply from the user
//   trsac_req_out, trsac_reply_out  status / reply to the transaction engine
//   dev_configval, ep_halt          device state reported by the requests
//   tx_rd                           engine consumed the current IN byte
//   tx_data, tx_last, tx_zlp        IN data-stage byte stream
module usb_stdreply
    import usb_pkg::*;
#(
    parameter bit SELF_POWERED  = 1'b0,
    parameter bit REMOTE_WAKEUP = 1'b0
) (
    input  logic               clk,
    input  logic               rst0_async,
    input  logic [BYTE_W-1:0]  bm_request_type,
    input  logic [BYTE_W-1:0]  b_request,
    input  logic [EP_W-1:0]    w_index,
    input  logic [WLEN_W-1:0]  w_length,
    input  logic [CODE_W-1:0]  trsac_type,
    input  logic [EP_W-1:0]    trsac_ep,
    input  logic [CODE_W-1:0]  trsac_req_in,
    input  logic [CODE_W-1:0]  trsac_reply_in,
    output logic [CODE_W-1:0]  trsac_req_out,
    output logic [CODE_W-1:0]  trsac_reply_out,
    input  logic [BYTE_W-1:0]  dev_configval,
    input  logic [15:0]        ep_halt,
    input  logic               tx_rd,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               tx_last,
    output logic               tx_zlp
);

    stdreply_state_e   state_q;
    stdreply_state_e   ret_q;
    req_kind_e         kind_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [EP_W-1:0]   idx_q;
    logic              act_q;

    setup_pkt_t        setup_c;
    req_kind_e         kind_c;
    logic              xact_c;
    logic              ep0_c;
    logic              setup_ep0_c;
    logic              intercept_c;
    logic              in_ep0_c;
    logic              out_ep0_c;
    logic              ctl_busy_c;
    logic              redecode_c;
    logic              foreign_c;
    logic              pass_c;
    logic              halt_bit_c;

    // Transaction classification and pass-through decision.
    always_comb begin
        setup_c.bm_request_type = bm_request_type;
        setup_c.b_request       = b_request;
        setup_c.w_index         = w_index;
        setup_c.w_length        = w_length;
        kind_c      = decode_std_req(setup_c.bm_request_type, setup_c.b_request);
        xact_c      = (trsac_req_in == REQ_ACTIVE);
        ep0_c       = (trsac_ep == '0);
        setup_ep0_c = xact_c && ep0_c && (trsac_type == TYPE_SETUP);
        intercept_c = setup_ep0_c && (kind_c != KIND_NONE);
        in_ep0_c    = xact_c && ep0_c && (trsac_type == TYPE_IN);
        out_ep0_c   = xact_c && ep0_c && (trsac_type == TYPE_OUT);
        ctl_busy_c  = (state_q == ST_DATA_IN) || (state_q == ST_STATUS_OUT);
        // A new SETUP on ep0 aborts a running transfer and is decoded afresh.
        redecode_c  = setup_ep0_c && ctl_busy_c;
        // Traffic for other endpoints may interleave with the control transfer.
        foreign_c   = xact_c && !ep0_c && ctl_busy_c;
        // The user's reply is visible already in the cycle the bypass starts.
        pass_c      = (state_q == ST_BYPASS)
                   || ((state_q == ST_IDLE) && xact_c && !intercept_c)
                   || (redecode_c && !intercept_c)
                   || foreign_c;
    end

    // Status always follows the user; reply is ours unless bypassing.
    always_comb begin
        trsac_req_out   = trsac_req_in;
        trsac_reply_out = REPLY_ACK;
        if (pass_c) begin
            trsac_reply_out = trsac_reply_in;
        end
        if (!rst0_async) begin
            trsac_req_out   = REQ_OK;
            trsac_reply_out = REPLY_ACK;
        end
    end

    assign halt_bit_c = ep_halt[idx_q];
    assign tx_last    = (cnt_q == (len_q - CNT_W'(1)));
    assign tx_zlp     = (len_q == '0);

    usb_stdreply_rom #(
        .SELF_POWERED  (SELF_POWERED),
        .REMOTE_WAKEUP (REMOTE_WAKEUP)
    ) u_rom (
        .kind_i      (kind_q),
        .cnt_i       (cnt_q),
        .configval_i (dev_configval),
        .halt_i      (halt_bit_c),
        .data_o      (tx_data)
    );

    // Control-transfer sequencer.
    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            kind_q  <= KIND_NONE;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            act_q   <= 1'b0;
        end else if (redecode_c) begin
            act_q  <= 1'b0;
            cnt_q  <= '0;
            kind_q <= KIND_NONE;
            len_q  <= '0;
            idx_q  <= '0;
            ret_q  <= ST_IDLE;
            state_q <= intercept_c ? ST_SETUP : ST_BYPASS;
        end else if (foreign_c) begin
            ret_q   <= state_q;
            state_q <= ST_BYPASS;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xact_c) begin
                        ret_q   <= ST_IDLE;
                        state_q <= intercept_c ? ST_SETUP : ST_BYPASS;
                    end
                end
                ST_SETUP: begin
                    kind_q <= kind_c;
                    len_q  <= clip_len(setup_c.w_length, natural_len(kind_c));
                    idx_q  <= setup_c.w_index;
                    cnt_q  <= '0;
                    act_q  <= 1'b0;
                    if (trsac_req_in == REQ_OK) begin
                        state_q <= ST_DATA_IN;
                    end else if (trsac_req_in == REQ_FAIL) begin
                        state_q <= ST_IDLE;
                        kind_q  <= KIND_NONE;
                        len_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                ST_DATA_IN: begin
                    if (tx_rd && (cnt_q < len_q)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (in_ep0_c) begin
                        act_q <= 1'b1;
                    end else if (act_q && (trsac_req_in == REQ_OK)) begin
                        act_q   <= 1'b0;
                        state_q <= ST_STATUS_OUT;
                    end else if (act_q && (trsac_req_in == REQ_FAIL)) begin
                        // Host will retry the IN: replay from the first byte.
                        act_q <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                ST_STATUS_OUT: begin
                    if (out_ep0_c) begin
                        act_q <= 1'b1;
                    end else if (act_q && ((trsac_req_in == REQ_OK) ||
                                           (trsac_req_in == REQ_FAIL))) begin
                        act_q   <= 1'b0;
                        state_q <= ST_IDLE;
                        kind_q  <= KIND_NONE;
                        len_q   <= '0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                ST_BYPASS: begin
                    if (!xact_c) begin
                        state_q <= ret_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_stdreply.sv
// Randomised scoreboard bench for usb_stdreply.
module tb_usb_stdreply;
    import usb_pkg::*;

    localparam bit SP = 1'b1;
    localparam bit RW = 1'b0;

    logic        clk = 1'b0;
    logic        rst0_async;
    logic [7:0]  bm_request_type, b_request;
    logic [3:0]  w_index;
    logic [15:0] w_length;
    logic [1:0]  trsac_type;
    logic [3:0]  trsac_ep;
    logic [1:0]  trsac_req_in, trsac_reply_in;
    logic [1:0]  trsac_req_out, trsac_reply_out;
    logic [7:0]  dev_configval;
    logic [15:0] ep_halt;
    logic        tx_rd;
    logic [7:0]  tx_data;
    logic        tx_last, tx_zlp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    usb_stdreply #(.SELF_POWERED(SP), .REMOTE_WAKEUP(RW)) dut (
        .clk             (clk),
        .rst0_async      (rst0_async),
        .bm_request_type (bm_request_type),
        .b_request       (b_request),
        .w_index         (w_index),
        .w_length        (w_length),
        .trsac_type      (trsac_type),
        .trsac_ep        (trsac_ep),
        .trsac_req_in    (trsac_req_in),
        .trsac_reply_in  (trsac_reply_in),
        .trsac_req_out   (trsac_req_out),
        .trsac_reply_out (trsac_reply_out),
        .dev_configval   (dev_configval),
        .ep_halt         (ep_halt),
        .tx_rd           (tx_rd),
        .tx_data         (tx_data),
        .tx_last         (tx_last),
        .tx_zlp          (tx_zlp)
    );

    typedef struct packed { logic [7:0] d; logic last; } data_exp_t;
    typedef struct packed { logic [1:0] rep; logic [1:0] req; logic chk_zlp; logic zlp; } rep_exp_t;

    data_exp_t data_q[$];
    rep_exp_t  rep_q[$];
    data_exp_t mon_d;
    rep_exp_t  mon_r;
    logic [1:0] prev_req = 2'd0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a consumed byte pops a data expectation; a transaction end pops a reply expectation.
    always @(negedge clk) begin
        if (rst0_async) begin
            if (tx_rd) begin
                if (data_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_tx_rd tx_data=0x%0h required=no_byte", tx_data);
                end else begin
                    mon_d = data_q.pop_front();
                    check("tx_data", 16'(tx_data), 16'(mon_d.d));
                    check("tx_last", 16'(tx_last), 16'(mon_d.last));
                    check("tx_zlp_on_rd", 16'(tx_zlp), 16'd0);
                end
            end
            if (prev_req == REQ_ACTIVE && trsac_req_in != REQ_ACTIVE) begin
                if (rep_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_xact_end reply=%0d required=none", trsac_reply_out);
                end else begin
                    mon_r = rep_q.pop_front();
                    check("reply_out", 16'(trsac_reply_out), 16'(mon_r.rep));
                    check("req_out", 16'(trsac_req_out), 16'(mon_r.req));
                    if (mon_r.chk_zlp) check("tx_zlp", 16'(tx_zlp), 16'(mon_r.zlp));
                end
            end
        end
        prev_req = trsac_req_in;
    end

    // Reference model: the data stage is the request's natural byte list cut to w_length.
    function automatic int model_nat_len(input int k);
        if (k == 0) return 1;
        if (k >= 1 && k <= 3) return 2;
        return 0;
    endfunction

    function automatic logic [7:0] model_byte(input int k, input int i, input logic [7:0] cfg, input logic halt);
        case (k)
            0:       return cfg;
            1:       return (i == 0) ? {6'b0, RW, SP} : 8'h00;
            3:       return (i == 0) ? {7'b0, halt} : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_xact(input logic [1:0] ty, input logic [3:0] ep, input logic [1:0] fin,
                            input logic [1:0] urep, input int nrd, input logic [1:0] exp_rep,
                            input bit chk_zlp, input bit exp_zlp);
        rep_exp_t r;
        r.rep = exp_rep; r.req = fin; r.chk_zlp = chk_zlp; r.zlp = exp_zlp;
        rep_q.push_back(r);
        tick();
        trsac_type = ty; trsac_ep = ep; trsac_req_in = REQ_ACTIVE; trsac_reply_in = urep;
        for (int i = 0; i < nrd; i++) begin
            tick(); tx_rd = 1'b1;
            tick(); tx_rd = 1'b0;
        end
        tick();
        tick(); trsac_req_in = fin;
        tick(); trsac_req_in = REQ_OK;
    endtask

    function automatic logic [1:0] rand_reply();
        return 2'($urandom_range(0, 2));
    endfunction

    // An OUT on ep0 is only passed through when the block is idle.
    task automatic probe_idle();
        logic [1:0] ur;
        ur = ($urandom_range(0, 1) == 0) ? REPLY_NAK : REPLY_STALL;
        run_xact(TYPE_OUT, 4'd0, REQ_OK, ur, 0, ur, 1'b0, 1'b0);
    endtask

    task automatic push_bytes(input int k, input int n, input logic [3:0] wi);
        data_exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d    = model_byte(k, i, dev_configval, ep_halt[wi]);
            e.last = (i == n - 1);
            data_q.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"}, 16'(tx_data), 16'h00);
        check({tag, "_tx_last"}, 16'(tx_last), 16'd0);
        check({tag, "_tx_zlp"},  16'(tx_zlp), 16'd1);
        check({tag, "_req_out"}, 16'(trsac_req_out), 16'(REQ_OK));
        check({tag, "_reply_out"}, 16'(trsac_reply_out), 16'(REPLY_ACK));
    endtask

    // Setup stage of an intercepted request; returns the expected data length.
    task automatic start_std(input int k, input logic [15:0] wl, input logic [3:0] wi, output int n);
        case (k)
            0:       begin bm_request_type = 8'h80; b_request = 8'h08; end
            1:       begin bm_request_type = 8'h80; b_request = 8'h00; end
            2:       begin bm_request_type = 8'h81; b_request = 8'h00; end
            default: begin bm_request_type = 8'h82; b_request = 8'h00; end
        endcase
        w_index = wi; w_length = wl;
        run_xact(TYPE_SETUP, 4'd0, REQ_OK, rand_reply(), 0, REPLY_ACK, 1'b0, 1'b0);
        n = (int'(wl) < model_nat_len(k)) ? int'(wl) : model_nat_len(k);
        // Header changes after the setup stage must not affect the transfer.
        bm_request_type = 8'($urandom); w_index = 4'($urandom); w_length = 16'($urandom);
    endtask

    task automatic do_transfer(input int k, input logic [15:0] wl, input logic [3:0] wi,
                               input bit fail_first, input bit foreign, input logic [1:0] sfin);
        int n;
        logic [1:0] ur;
        logic [3:0] sep;
        if (k > 3) begin
            sep = 4'd0;
            case ($urandom_range(0, 3))
                0:       begin bm_request_type = 8'h40; b_request = 8'($urandom); end
                1:       begin bm_request_type = 8'h80; b_request = 8'h06; end
                2:       begin bm_request_type = 8'h00; b_request = 8'h09; end
                default: begin bm_request_type = 8'h80; b_request = 8'h08;
                               sep = 4'($urandom_range(1, 15)); end
            endcase
            ur = rand_reply();
            run_xact(TYPE_SETUP, sep, REQ_OK, ur, 0, ur, 1'b0, 1'b0);
            probe_idle();
            return;
        end
        start_std(k, wl, wi, n);
        if (foreign) begin
            ur = rand_reply();
            run_xact(2'($urandom_range(0, 2)), 4'($urandom_range(1, 15)),
                     ($urandom_range(0, 1) == 0) ? REQ_OK : REQ_FAIL, ur, 0, ur, 1'b0, 1'b0);
        end
        if (fail_first) begin
            push_bytes(k, n, wi);
            run_xact(TYPE_IN, 4'd0, REQ_FAIL, rand_reply(), n, REPLY_ACK, 1'b1, n == 0);
        end
        push_bytes(k, n, wi);
        run_xact(TYPE_IN, 4'd0, REQ_OK, rand_reply(), n, REPLY_ACK, 1'b1, n == 0);
        run_xact(TYPE_OUT, 4'd0, sfin, rand_reply(), 0, REPLY_ACK, 1'b0, 1'b0);
        probe_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time_limit_reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] wl;
        rst0_async = 1'b0;
        bm_request_type = '0; b_request = '0; w_index = '0; w_length = '0;
        trsac_type = TYPE_SETUP; trsac_ep = '0;
        trsac_req_in = REQ_FAIL; trsac_reply_in = REPLY_STALL;
        dev_configval = 8'h03; ep_halt = 16'h0000; tx_rd = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        trsac_req_in = REQ_OK; trsac_reply_in = REPLY_ACK;
        tick(); rst0_async = 1'b1;
        tick();

        // Directed scenarios.
        do_transfer(0, 16'd64, 4'd0, 1'b0, 1'b0, REQ_OK);
        ep_halt = 16'h0004;
        do_transfer(3, 16'd64, 4'd2, 1'b0, 1'b0, REQ_OK);
        do_transfer(3, 16'd1, 4'd2, 1'b0, 1'b0, REQ_OK);
        do_transfer(1, 16'd0, 4'd0, 1'b0, 1'b0, REQ_OK);
        do_transfer(1, 16'd64, 4'd0, 1'b1, 1'b0, REQ_FAIL);
        do_transfer(2, 16'd2, 4'd5, 1'b0, 1'b1, REQ_OK);

        // Vendor request: user reply passes straight through.
        bm_request_type = 8'h40; b_request = 8'h01;
        run_xact(TYPE_SETUP, 4'd0, REQ_OK, REPLY_NAK, 0, REPLY_NAK, 1'b0, 1'b0);
        run_xact(TYPE_SETUP, 4'd0, REQ_FAIL, REPLY_STALL, 0, REPLY_STALL, 1'b0, 1'b0);
        probe_idle();

        // New vendor SETUP while waiting for the status stage aborts the transfer.
        dev_configval = 8'h5a;
        start_std(0, 16'd64, 4'd0, n);
        push_bytes(0, n, 4'd0);
        run_xact(TYPE_IN, 4'd0, REQ_OK, REPLY_NAK, n, REPLY_ACK, 1'b1, 1'b0);
        bm_request_type = 8'h40; b_request = 8'h02;
        run_xact(TYPE_SETUP, 4'd0, REQ_OK, REPLY_NAK, 0, REPLY_NAK, 1'b0, 1'b0);
        trsac_reply_in = REPLY_STALL;
        @(negedge clk);
        check_reset_outputs("abort");
        tick();
        probe_idle();

        // Reset in the middle of the data stage.
        ep_halt = 16'h0004;
        start_std(3, 16'd64, 4'd2, n);
        @(negedge clk);
        check("pre_reset_tx_data", 16'(tx_data), 16'(model_byte(3, 0, dev_configval, 1'b1)));
        #2 rst0_async = 1'b0; trsac_req_in = REQ_FAIL; trsac_reply_in = REPLY_STALL;
        #1 check_reset_outputs("in_reset");
        tick(); rst0_async = 1'b1; trsac_req_in = REQ_OK; trsac_reply_in = REPLY_ACK;
        @(negedge clk);
        check_reset_outputs("after_reset");
        tick();
        run_xact(TYPE_IN, 4'd0, REQ_OK, REPLY_NAK, 0, REPLY_NAK, 1'b0, 1'b0);
        probe_idle();

        // Randomised transfers.
        for (int it = 0; it < 40; it++) begin
            dev_configval = 8'($urandom);
            ep_halt = 16'($urandom);
            case ($urandom_range(0, 4))
                0: wl = 16'd0;
                1: wl = 16'd1;
                2: wl = 16'd2;
                3: wl = 16'd64;
                default: wl = 16'($urandom);
            endcase
            do_transfer($urandom_range(0, 4), wl, 4'($urandom),
                        $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                        ($urandom_range(0, 1) == 0) ? REQ_OK : REQ_FAIL);
        end

        repeat (4) tick();
        checks++;
        if (data_q.size() != 0 || rep_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain data_left=%0d reply_left=%0d required=0", data_q.size(), rep_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
